// File: rtl/opcode_encoder_issue.sv
// Collects one-hot operation requests into a pending set and issues them one at a
// time as a 3-bit opcode over a valid/ready handshake, with round-robin or fixed priority.
module opcode_encoder_issue #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic       ready,
  output logic [2:0] opcode,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overflow,
  output logic       state_o
);

  // Handshake: an opcode transfers on a rising edge where valid && ready. Once valid
  // rises, opcode and valid stay fixed until that transfer or rst; valid never
  // depends combinationally on ready.

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t     state_q;
  logic [2:0] opcode_q;
  logic       valid_q;
  logic [7:0] pending_q, pending_d;
  logic       overflow_q, overflow_d;
  logic [2:0] ptr_q, ptr_d;

  logic       accept;
  logic [7:0] acc_mask;
  logic [7:0] remain;
  logic [2:0] base;
  logic [2:0] sel;
  logic       found;
  logic [2:0] idx;

  always_comb begin
    accept     = valid_q && ready;
    acc_mask   = accept ? (8'b1 << opcode_q) : 8'b0;
    remain     = pending_q & ~acc_mask;
    // Set wins over the clear of an accepted bit, so a same-cycle re-request survives.
    pending_d  = remain | req_in;
    overflow_d = overflow_q | (|(req_in & remain));
    ptr_d      = accept ? opcode_q + 3'd1 : ptr_q;
  end

  // The arbiter sees only registered state: same-cycle req_in never takes part.
  always_comb begin
    base  = RR_EN ? ptr_d : 3'd0;
    sel   = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = base + 3'(k);
      if (!found && remain[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      opcode_q   <= 3'd0;
      valid_q    <= 1'b0;
      pending_q  <= 8'd0;
      overflow_q <= 1'b0;
      ptr_q      <= 3'd0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      ptr_q      <= ptr_d;
      case (state_q)
        IDLE: begin
          if (found) begin
            opcode_q <= sel;
            valid_q  <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            if (found) begin
              opcode_q <= sel;
              valid_q  <= 1'b1;
              state_q  <= ISSUE;
            end else begin
              valid_q  <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign opcode   = opcode_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_opcode_encoder_issue.sv
// Directed bench for opcode_encoder_issue: a round-robin and a fixed-priority instance
// share one stimulus stream; expected values are hand-computed constants.
module tb_opcode_encoder_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic       ready;

  logic [2:0] opcode, opcode_fp;
  logic       valid, valid_fp;
  logic [7:0] pending, pending_fp;
  logic       overflow, overflow_fp;
  logic       state_dbg, state_dbg_fp;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  opcode_encoder_issue #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ready(ready),
    .opcode(opcode), .valid(valid), .pending(pending),
    .overflow(overflow), .state_o(state_dbg)
  );

  opcode_encoder_issue #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req_in(req_in), .ready(ready),
    .opcode(opcode_fp), .valid(valid_fp), .pending(pending_fp),
    .overflow(overflow_fp), .state_o(state_dbg_fp)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    req_in = 8'h00;
    ready  = 1'b0;
    tick();
    tick();
    check("rst_valid",    {7'b0, valid},    8'h0);
    check("rst_opcode",   {5'b0, opcode},   8'h0);
    check("rst_pending",  pending,          8'h00);
    check("rst_overflow", {7'b0, overflow}, 8'h0);
    check("rst_state",    {7'b0, state_dbg}, 8'h0);
    rst = 1'b0;
    tick();

    // Burst of all eight requests, ready held high
    ready  = 1'b1;
    req_in = 8'hFF;
    tick();
    check("burst_pend_e1",  pending,          8'hFF);
    check("burst_valid_e1", {7'b0, valid},    8'h0);
    req_in = 8'h00;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("burst_valid_%0d", i), {7'b0, valid}, 8'h1);
      check($sformatf("burst_op_%0d", i),    {5'b0, opcode}, 8'(i));
      check($sformatf("burst_pend_%0d", i),  pending, 8'hFF << i);
      tick();
    end
    check("burst_valid_end", {7'b0, valid}, 8'h0);
    check("burst_pend_end",  pending,       8'h00);

    // Single request, two-edge latency
    req_in = 8'h10;
    tick();
    check("single_pend_e1",  pending,       8'h10);
    check("single_valid_e1", {7'b0, valid}, 8'h0);
    req_in = 8'h00;
    tick();
    check("single_valid_e2", {7'b0, valid},  8'h1);
    check("single_op_e2",    {5'b0, opcode}, 8'h4);
    check("single_state_e2", {7'b0, state_dbg}, 8'h1);
    tick();
    check("single_valid_e3", {7'b0, valid},  8'h0);
    check("single_pend_e3",  pending,        8'h00);
    check("single_op_hold",  {5'b0, opcode}, 8'h4);

    // Arbitration: serve 5 so the round-robin pointer becomes 6
    req_in = 8'h20;
    tick();
    req_in = 8'h00;
    tick();
    check("arb_serve5", {5'b0, opcode}, 8'h5);
    tick();
    req_in = 8'h41;
    tick();
    req_in = 8'h00;
    tick();
    check("arb_rr_first",  {5'b0, opcode},    8'h6);
    check("arb_fp_first",  {5'b0, opcode_fp}, 8'h0);
    tick();
    check("arb_rr_second", {5'b0, opcode},    8'h0);
    check("arb_fp_second", {5'b0, opcode_fp}, 8'h6);
    check("arb_rr_valid2", {7'b0, valid},     8'h1);
    tick();
    check("arb_rr_done",   {7'b0, valid},     8'h0);
    check("arb_fp_done",   {7'b0, valid_fp},  8'h0);

    // Backpressure with a merged re-request during the stall
    ready  = 1'b0;
    req_in = 8'h04;
    tick();
    req_in = 8'h00;
    tick();
    check("bp_valid", {7'b0, valid},  8'h1);
    check("bp_op",    {5'b0, opcode}, 8'h2);
    for (int i = 0; i < 5; i++) begin
      req_in = (i == 2) ? 8'h04 : 8'h00;
      tick();
      check($sformatf("bp_stall_valid_%0d", i), {7'b0, valid},  8'h1);
      check($sformatf("bp_stall_op_%0d", i),    {5'b0, opcode}, 8'h2);
    end
    req_in = 8'h00;
    check("bp_overflow", {7'b0, overflow}, 8'h1);
    ready = 1'b1;
    tick();
    check("bp_acc_valid",    {7'b0, valid},    8'h0);
    check("bp_acc_pend",     pending,          8'h00);
    check("bp_acc_overflow", {7'b0, overflow}, 8'h1);
    tick();
    check("bp_no_reissue",   {7'b0, valid},    8'h0);
    check("bp_ovf_sticky",   {7'b0, overflow}, 8'h1);

    // Asynchronous reset mid-handshake
    ready  = 1'b0;
    req_in = 8'h0C;
    tick();
    req_in = 8'h00;
    tick();
    check("mr_valid_pre", {7'b0, valid}, 8'h1);
    check("mr_pend_pre",  pending,       8'h0C);
    #2 rst = 1'b1;
    #1;
    check("mr_valid",    {7'b0, valid},    8'h0);
    check("mr_pending",  pending,          8'h00);
    check("mr_overflow", {7'b0, overflow}, 8'h0);
    check("mr_opcode",   {5'b0, opcode},   8'h0);
    tick();
    rst   = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    tick();
    check("mr_idle_valid", {7'b0, valid}, 8'h0);
    check("mr_idle_pend",  pending,       8'h00);

    // Set-wins collision on opcode 3
    req_in = 8'h08;
    tick();
    req_in = 8'h00;
    tick();
    check("sw_op",    {5'b0, opcode}, 8'h3);
    check("sw_valid", {7'b0, valid},  8'h1);
    req_in = 8'h08;
    tick();
    req_in = 8'h00;
    check("sw_gap_valid", {7'b0, valid},    8'h0);
    check("sw_gap_pend",  pending,          8'h08);
    check("sw_overflow",  {7'b0, overflow}, 8'h0);
    tick();
    check("sw_reissue_valid", {7'b0, valid},  8'h1);
    check("sw_reissue_op",    {5'b0, opcode}, 8'h3);
    tick();
    check("sw_end_valid",    {7'b0, valid},    8'h0);
    check("sw_end_pend",     pending,          8'h00);
    check("sw_end_overflow", {7'b0, overflow}, 8'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
